// File: rtl/alu_issue_if.sv
// alu_issue_if
//   Bundles the decode/issue stage's two handshakes into one interface.
//   Upstream side : in_valid/in_ready with instr, rs_val, rt_val.
//   Downstream side: out_valid/out_ready with alu_opcode, op1, op2,
//                    dest_reg, writes_reg, illegal.
//   slave  modport : seen by alu_issue_stage.
//   master modport : seen by whatever drives the stage and consumes its output.
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  alu_opcode;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  dest_reg;
    logic        writes_reg;
    logic        illegal;

    modport slave (
        input  in_valid, instr, rs_val, rt_val, out_ready,
        output in_ready, out_valid, alu_opcode, op1, op2, dest_reg, writes_reg, illegal
    );

    modport master (
        output in_valid, instr, rs_val, rt_val, out_ready,
        input  in_ready, out_valid, alu_opcode, op1, op2, dest_reg, writes_reg, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Decodes a MIPS instruction word plus its register-read values into the
//   ALU triple (alu_opcode, op1, op2) with destination info, behind a
//   registered valid/ready stage with a one-entry skid buffer.
// Ports
//   clk    : clock, all state on rising edge
//   reset  : synchronous active-high reset (wins over flush)
//   flush  : synchronous flush, drops output and skid entries and any
//            same-cycle input
//   bus    : alu_issue_if.slave, upstream and downstream handshakes
// in_ready is a pure register (true when the skid is empty next cycle), so
// there is no combinational path from in_valid/out_ready to in_ready.
module alu_issue_stage #(
    parameter logic [5:0] ILLEGAL_OP = 6'h3F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    alu_issue_if.slave  bus
);

    typedef struct packed {
        logic [5:0]  alu_opcode;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  dest_reg;
        logic        writes_reg;
        logic        illegal;
    } bundle_t;

    bundle_t dec;
    bundle_t out_reg, out_next;
    bundle_t skid_reg, skid_next;
    logic    out_valid_reg, out_valid_next;
    logic    skid_valid_reg, skid_valid_next;
    logic    in_ready_reg;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic        unused_fields;

    assign opcode = bus.instr[31:26];
    assign funct  = bus.instr[5:0];
    assign imm16  = bus.instr[15:0];
    // rs/rt index fields are consumed upstream by the register file.
    assign unused_fields = ^bus.instr[25:16];

    // ---------------- decode ----------------
    always_comb begin
        dec = '0;
        dec.alu_opcode = ILLEGAL_OP;
        dec.illegal    = 1'b1;
        if (opcode == 6'h00) begin
            case (funct)
                6'h00, 6'h02, 6'h03: begin
                    dec.alu_opcode = funct;
                    dec.op1        = {27'b0, bus.instr[10:6]};
                    dec.op2        = bus.rt_val;
                    dec.dest_reg   = bus.instr[15:11];
                    dec.illegal    = 1'b0;
                end
                6'h04, 6'h06, 6'h07: begin
                    dec.alu_opcode = funct;
                    dec.op1        = {27'b0, bus.rs_val[4:0]};
                    dec.op2        = bus.rt_val;
                    dec.dest_reg   = bus.instr[15:11];
                    dec.illegal    = 1'b0;
                end
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h2A, 6'h2B: begin
                    dec.alu_opcode = funct;
                    dec.op1        = bus.rs_val;
                    dec.op2        = bus.rt_val;
                    dec.dest_reg   = bus.instr[15:11];
                    dec.illegal    = 1'b0;
                end
                default: ;
            endcase
        end else begin
            case (opcode)
                6'h08, 6'h09, 6'h0A, 6'h0B: begin
                    dec.alu_opcode = opcode;
                    dec.op1        = bus.rs_val;
                    dec.op2        = {{16{imm16[15]}}, imm16};
                    dec.dest_reg   = bus.instr[20:16];
                    dec.illegal    = 1'b0;
                end
                6'h0C, 6'h0D, 6'h0E: begin
                    dec.alu_opcode = opcode;
                    dec.op1        = bus.rs_val;
                    dec.op2        = {16'b0, imm16};
                    dec.dest_reg   = bus.instr[20:16];
                    dec.illegal    = 1'b0;
                end
                6'h0F: begin
                    // lui: the ALU shifts op2 into the upper half itself.
                    dec.alu_opcode = opcode;
                    dec.op1        = 32'b0;
                    dec.op2        = {16'b0, imm16};
                    dec.dest_reg   = bus.instr[20:16];
                    dec.illegal    = 1'b0;
                end
                default: ;
            endcase
        end
        dec.writes_reg = !dec.illegal && (dec.dest_reg != 5'd0);
    end

    // ---------------- handshake / skid ----------------
    logic accept;
    logic drain;

    assign accept = bus.in_valid && in_ready_reg;
    assign drain  = out_valid_reg && bus.out_ready;

    always_comb begin
        out_next        = out_reg;
        out_valid_next  = out_valid_reg;
        skid_next       = skid_reg;
        skid_valid_next = skid_valid_reg;
        if (!out_valid_reg || drain) begin
            // Output slot frees up: the older skid entry goes first. While the
            // skid is full in_ready is low, so accept cannot also be set here.
            if (skid_valid_reg) begin
                out_next        = skid_reg;
                out_valid_next  = 1'b1;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                out_next       = dec;
                out_valid_next = 1'b1;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (accept) begin
            skid_next       = dec;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            out_reg        <= '0;
            out_valid_reg  <= 1'b0;
            skid_reg       <= '0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
        end else begin
            out_reg        <= out_next;
            out_valid_reg  <= out_valid_next;
            skid_reg       <= skid_next;
            skid_valid_reg <= skid_valid_next;
            in_ready_reg   <= !skid_valid_next;
        end
    end

    assign bus.in_ready   = in_ready_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.alu_opcode = out_reg.alu_opcode;
    assign bus.op1        = out_reg.op1;
    assign bus.op2        = out_reg.op2;
    assign bus.dest_reg   = out_reg.dest_reg;
    assign bus.writes_reg = out_reg.writes_reg;
    assign bus.illegal    = out_reg.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    alu_issue_if bus ();

    alu_issue_stage #(.ILLEGAL_OP(6'h3F)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [5:0]  exp_op;
        logic [31:0] exp_op1;
        logic [31:0] exp_op2;
        logic [4:0]  exp_dest;
        logic        exp_wr;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[12];

    // Records dest_reg of every bundle transferred downstream, in order.
    logic [4:0] delivered[$];
    always @(posedge clk) begin
        if (!reset && !flush && bus.out_valid && bus.out_ready)
            delivered.push_back(bus.dest_reg);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        bus.in_valid = v;
        bus.instr    = i;
        bus.rs_val   = rs;
        bus.rt_val   = rt;
    endtask

    // addi $k, $0, k : tags an item by its destination register.
    function automatic logic [31:0] addi_tag(input int k);
        logic [31:0] w;
        w = 32'h2000_0000 | (32'(k) << 16) | 32'(k);
        return w;
    endfunction

    task automatic chk_cleared(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        chk({tag, "_opcode"},    32'(bus.alu_opcode), 32'd0);
        chk({tag, "_op1"},       bus.op1, 32'd0);
        chk({tag, "_op2"},       bus.op2, 32'd0);
        chk({tag, "_dest"},      32'(bus.dest_reg), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{"addi",  32'h2208FFFF, 32'd5,        32'd0,        6'h08, 32'd5,        32'hFFFFFFFF, 5'd8, 1'b1, 1'b0};
        vecs[1]  = '{"sll",   32'h000A4900, 32'd0,        32'd3,        6'h00, 32'd4,        32'd3,        5'd9, 1'b1, 1'b0};
        vecs[2]  = '{"srav",  32'h00221807, 32'h25,       32'h80000000, 6'h07, 32'd5,        32'h80000000, 5'd3, 1'b1, 1'b0};
        vecs[3]  = '{"lui",   32'h3C081234, 32'hDEADBEEF, 32'd7,        6'h0F, 32'd0,        32'h00001234, 5'd8, 1'b1, 1'b0};
        vecs[4]  = '{"lw",    32'h8C080000, 32'd1,        32'd2,        6'h3F, 32'd0,        32'd0,        5'd0, 1'b0, 1'b1};
        vecs[5]  = '{"mult",  32'h00221818, 32'd1,        32'd2,        6'h3F, 32'd0,        32'd0,        5'd0, 1'b0, 1'b1};
        vecs[6]  = '{"add0",  32'h00220020, 32'd1,        32'd2,        6'h20, 32'd1,        32'd2,        5'd0, 1'b0, 1'b0};
        vecs[7]  = '{"andi",  32'h3048F0F0, 32'h12345678, 32'd0,        6'h0C, 32'h12345678, 32'h0000F0F0, 5'd8, 1'b1, 1'b0};
        vecs[8]  = '{"slti",  32'h28248000, 32'd9,        32'd0,        6'h0A, 32'd9,        32'hFFFF8000, 5'd4, 1'b1, 1'b0};
        vecs[9]  = '{"sltu",  32'h0022182B, 32'hAAAA5555, 32'h0F0F0F0F, 6'h2B, 32'hAAAA5555, 32'h0F0F0F0F, 5'd3, 1'b1, 1'b0};
        vecs[10] = '{"srl31", 32'h00022FC2, 32'hFFFFFFFF, 32'h12345678, 6'h02, 32'd31,       32'h12345678, 5'd5, 1'b1, 1'b0};
        vecs[11] = '{"fn01",  32'h00221801, 32'd1,        32'd2,        6'h3F, 32'd0,        32'd0,        5'd0, 1'b0, 1'b1};

        reset = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk_cleared("reset");

        // ---------- decode table, streamed back to back ----------
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].instr, vecs[i].rs_val, vecs[i].rt_val);
            tick();
            drive(1'b0, 32'd0, 32'd0, 32'd0);
            chk({vecs[i].name, "_valid"},   32'(bus.out_valid),  32'd1);
            chk({vecs[i].name, "_opcode"},  32'(bus.alu_opcode), 32'(vecs[i].exp_op));
            chk({vecs[i].name, "_op1"},     bus.op1,             vecs[i].exp_op1);
            chk({vecs[i].name, "_op2"},     bus.op2,             vecs[i].exp_op2);
            chk({vecs[i].name, "_dest"},    32'(bus.dest_reg),   32'(vecs[i].exp_dest));
            chk({vecs[i].name, "_wr"},      32'(bus.writes_reg), 32'(vecs[i].exp_wr));
            chk({vecs[i].name, "_illegal"}, 32'(bus.illegal),    32'(vecs[i].exp_ill));
        end
        tick();
        chk("drain_idle", 32'(bus.out_valid), 32'd0);

        // ---------- backpressure: A,B,C with output stalled ----------
        delivered.delete();
        bus.out_ready = 1'b0;
        drive(1'b1, addi_tag(1), 32'hA, 32'd0);
        tick();
        chk("bp_A_out", 32'(bus.dest_reg), 32'd1);
        chk("bp_ready_after_A", 32'(bus.in_ready), 32'd1);
        drive(1'b1, addi_tag(2), 32'hB, 32'd0);
        tick();
        chk("bp_ready_after_B", 32'(bus.in_ready), 32'd0);
        chk("bp_A_held", bus.op1, 32'hA);
        drive(1'b1, addi_tag(3), 32'hC, 32'd0);
        tick();
        chk("bp_C_blocked_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_A_stable", bus.op1, 32'hA);
        chk("bp_A_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_B_out", bus.op1, 32'hB);
        chk("bp_ready_reopen", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        chk("bp_C_out", bus.op1, 32'hC);
        tick();
        chk("bp_empty", 32'(bus.out_valid), 32'd0);
        chk("bp_count", 32'(delivered.size()), 32'd3);
        if (delivered.size() == 3) begin
            chk("bp_order0", 32'(delivered[0]), 32'd1);
            chk("bp_order1", 32'(delivered[1]), 32'd2);
            chk("bp_order2", 32'(delivered[2]), 32'd3);
        end

        // ---------- flush with output and skid full ----------
        bus.out_ready = 1'b0;
        drive(1'b1, addi_tag(4), 32'h4, 32'd0);
        tick();
        drive(1'b1, addi_tag(5), 32'h5, 32'd0);
        tick();
        chk("fl_full_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, addi_tag(6), 32'h6, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        chk_cleared("flush");
        delivered.delete();
        bus.out_ready = 1'b1;
        drive(1'b1, addi_tag(7), 32'h7, 32'd0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        chk("fl_new_item", 32'(bus.dest_reg), 32'd7);
        tick();
        chk("fl_no_stale", 32'(bus.out_valid), 32'd0);
        chk("fl_delivered", 32'(delivered.size()), 32'd1);

        // ---------- reset with output and skid full ----------
        bus.out_ready = 1'b0;
        drive(1'b1, addi_tag(10), 32'h10, 32'd0);
        tick();
        drive(1'b1, addi_tag(11), 32'h11, 32'd0);
        tick();
        chk("rs_full_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_cleared("rst2");
        bus.out_ready = 1'b1;
        tick();
        chk("rs_no_stale", 32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
